// File: rtl/seq_pattern_detector_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector_if
// Groups the button inputs and the status outputs of seq_pattern_detector.
//   ONE, ZERO  : push-button levels (already synchronised), driven by the master
//   OUT        : match indication
//   TICK       : one-cycle sampling strobe
//   HIST       : symbol history, LSB = newest symbol
//   STATE      : detector state encoding
//   MATCH_CNT  : match counter, only when SEQ_PATTERN_DETECTOR_MATCH_CNT_EN is set
// Modports: master (board/bench side), slave (detector side).
// Optional feature macro: SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
// -----------------------------------------------------------------------------
interface seq_pattern_detector_if #(
   parameter int PAT_LEN = 4
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
   , parameter int CNT_W = 8
`endif
);
   logic               ONE;
   logic               ZERO;
   logic               OUT;
   logic               TICK;
   logic [PAT_LEN-1:0] HIST;
   logic [1:0]         STATE;
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
   logic [CNT_W-1:0]   MATCH_CNT;

   modport master (output ONE, ZERO, input OUT, TICK, HIST, STATE, MATCH_CNT);
   modport slave  (input ONE, ZERO, output OUT, TICK, HIST, STATE, MATCH_CNT);
`else
   modport master (output ONE, ZERO, input OUT, TICK, HIST, STATE);
   modport slave  (input ONE, ZERO, output OUT, TICK, HIST, STATE);
`endif
endinterface

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
// Samples the ONE/ZERO buttons on a divided-clock tick, turns each press into
// a 1/0 symbol, shifts it into a history register and flags OUT when the last
// PAT_LEN symbols equal PATTERN (MSB = oldest symbol).
// Ports:
//   clock_in : system clock, all logic on its rising edge
//   RESET    : asynchronous, active-low reset
//   bus      : seq_pattern_detector_if.slave (ONE, ZERO in; OUT, TICK, HIST,
//              STATE and optionally MATCH_CNT out)
// Parameters: DIVISOR, PAT_LEN, PATTERN, OVERLAP, HOLD_OUT, CNT_W.
// Optional feature macro: SEQ_PATTERN_DETECTOR_MATCH_CNT_EN adds a wrapping
// match counter (MATCH_CNT) that is cleared only by reset.
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
   parameter int               DIVISOR  = 25000000,
   parameter int               PAT_LEN  = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
   parameter int               OVERLAP  = 1,
   parameter int               HOLD_OUT = 1
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
   , parameter int             CNT_W    = 8
`endif
) (
   input  logic                   clock_in,
   input  logic                   RESET,
   seq_pattern_detector_if.slave  bus
);

   localparam int DIV_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIVISOR - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [DIV_W-1:0]    cnt_reg, cnt_next;
   logic                tick_reg;
   logic                prev_one_reg, prev_zero_reg;
   logic [PAT_LEN-1:0]  hist_reg, hist_next, hist_shift;
   logic [FILL_W-1:0]   fill_reg, fill_next, fill_inc;
   logic                out_reg, out_next;
   logic                ev0, ev1, accept, match;

   // ---------------- sampling divider ----------------
   assign cnt_next = (cnt_reg == DIV_LAST) ? '0 : cnt_reg + 1'b1;

   // TICK is registered from the next counter value so it is high exactly
   // while the counter sits at DIVISOR-1 (permanently high for DIVISOR=1),
   // yet still reads 0 while in reset.
   always_ff @(posedge clock_in or negedge RESET) begin
      if (!RESET) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         tick_reg <= (cnt_next == DIV_LAST);
      end
   end

   // ---------------- press detection ----------------
   always_ff @(posedge clock_in or negedge RESET) begin
      if (!RESET) begin
         prev_one_reg  <= 1'b0;
         prev_zero_reg <= 1'b0;
      end else if (tick_reg) begin
         prev_one_reg  <= bus.ONE;
         prev_zero_reg <= bus.ZERO;
      end
   end

   // ZERO wins a simultaneous press, so ev1 is masked by ev0 and the shifted
   // symbol is simply ev1.
   assign ev0        = tick_reg & bus.ZERO & ~prev_zero_reg;
   assign ev1        = tick_reg & bus.ONE & ~prev_one_reg & ~ev0;
   assign accept     = (ev0 | ev1) && (state_reg != DONE);
   assign hist_shift = {hist_reg[PAT_LEN-2:0], ev1};
   assign fill_inc   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
   assign match      = accept && (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

   // ---------------- detector FSM ----------------
   always_ff @(posedge clock_in or negedge RESET) begin
      if (!RESET) begin
         state_reg <= EMPTY;
         hist_reg  <= '0;
         fill_reg  <= '0;
         out_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         hist_reg  <= hist_next;
         fill_reg  <= fill_next;
         out_reg   <= out_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hist_next  = hist_reg;
      fill_next  = fill_reg;
      out_next   = 1'b0;
      case (state_reg)
         EMPTY, FILL, ARMED: begin
            if (accept) begin
               hist_next  = hist_shift;
               fill_next  = fill_inc;
               state_next = (fill_inc == FILL_FULL) ? ARMED : FILL;
               if (match) begin
                  out_next = 1'b1;
                  if (HOLD_OUT != 0) begin
                     state_next = DONE;
                  end else if (OVERLAP == 0) begin
                     // Non-overlapping: the matched symbols are consumed.
                     hist_next  = '0;
                     fill_next  = '0;
                     state_next = EMPTY;
                  end
               end
            end
         end
         DONE: begin
            out_next = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.OUT   = out_reg;
   assign bus.TICK  = tick_reg;
   assign bus.HIST  = hist_reg;
   assign bus.STATE = state_reg;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
   // ---------------- match counter ----------------
   // Wraps naturally; the OVERLAP=0 history clear deliberately leaves it alone.
   logic [CNT_W-1:0] match_cnt_reg;

   always_ff @(posedge clock_in or negedge RESET) begin
      if (!RESET) begin
         match_cnt_reg <= '0;
      end else if (match) begin
         match_cnt_reg <= match_cnt_reg + 1'b1;
      end
   end

   assign bus.MATCH_CNT = match_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

   localparam int DIVISOR = 2;
   localparam int PAT_LEN = 4;
   localparam logic [3:0] PATTERN = 4'b1001;
   localparam int ND = 3;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
 `define TB_CNT_W(w) , .CNT_W(w)
`else
 `define TB_CNT_W(w)
`endif

   logic clock_in = 1'b0;
   logic RESET    = 1'b0;
   logic one_r    = 1'b0;
   logic zero_r   = 1'b0;

   always #5 clock_in = ~clock_in;

   int checks   = 0;
   int failures = 0;

   // dut0: HOLD_OUT=1; dut1: pulse + overlap; dut2: pulse, no overlap, CNT_W=2
   seq_pattern_detector_if #(.PAT_LEN(PAT_LEN) `TB_CNT_W(8)) if0 ();
   seq_pattern_detector_if #(.PAT_LEN(PAT_LEN) `TB_CNT_W(8)) if1 ();
   seq_pattern_detector_if #(.PAT_LEN(PAT_LEN) `TB_CNT_W(2)) if2 ();

   assign if0.ONE = one_r;  assign if0.ZERO = zero_r;
   assign if1.ONE = one_r;  assign if1.ZERO = zero_r;
   assign if2.ONE = one_r;  assign if2.ZERO = zero_r;

   seq_pattern_detector #(.DIVISOR(DIVISOR), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN),
      .OVERLAP(1), .HOLD_OUT(1) `TB_CNT_W(8)) dut0 (.clock_in(clock_in), .RESET(RESET), .bus(if0));
   seq_pattern_detector #(.DIVISOR(DIVISOR), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN),
      .OVERLAP(1), .HOLD_OUT(0) `TB_CNT_W(8)) dut1 (.clock_in(clock_in), .RESET(RESET), .bus(if1));
   seq_pattern_detector #(.DIVISOR(DIVISOR), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN),
      .OVERLAP(0), .HOLD_OUT(0) `TB_CNT_W(2)) dut2 (.clock_in(clock_in), .RESET(RESET), .bus(if2));

   // ---------------- behavioural reference model ----------------
   int  cfg_hold [ND] = '{1, 0, 0};
   int  cfg_ovl  [ND] = '{1, 1, 0};
   int  cfg_cntw [ND] = '{8, 8, 2};
   logic [3:0] pat_v;

   int  m_cnt;
   bit  m_prev_one, m_prev_zero;
   bit  m_tick_exp;
   bit  last_tick;
   int  m_sym [ND][PAT_LEN];   // oldest symbol first
   int  m_n   [ND];
   bit  m_done[ND];
   bit  m_out [ND];
   int  m_matches[ND];
   int  pulse_cnt[ND];

   function automatic void model_reset();
      m_cnt = 0; m_prev_one = 0; m_prev_zero = 0; m_tick_exp = 0;
      for (int d = 0; d < ND; d++) begin
         m_n[d] = 0; m_done[d] = 0; m_out[d] = 0; m_matches[d] = 0;
      end
   endfunction

   function automatic bit model_is_match(int d);
      if (m_n[d] != PAT_LEN) return 0;
      for (int i = 0; i < PAT_LEN; i++)
         if (m_sym[d][i] != int'(pat_v[PAT_LEN-1-i])) return 0;
      return 1;
   endfunction

   function automatic void model_edge();
      bit is_tick, p0, p1, have;
      int sym;
      have = 0; sym = 0;
      is_tick = (m_cnt == DIVISOR - 1);
      m_cnt = (m_cnt + 1) % DIVISOR;
      last_tick = is_tick;
      if (is_tick) begin
         p1 = one_r && !m_prev_one;
         p0 = zero_r && !m_prev_zero;
         m_prev_one = one_r; m_prev_zero = zero_r;
         if (p0 || p1) begin have = 1; sym = p0 ? 0 : 1; end
      end
      for (int d = 0; d < ND; d++) begin
         m_out[d] = m_done[d];
         if (have && !m_done[d]) begin
            if (m_n[d] == PAT_LEN) begin
               for (int i = 0; i < PAT_LEN - 1; i++) m_sym[d][i] = m_sym[d][i+1];
               m_sym[d][PAT_LEN-1] = sym;
            end else begin
               m_sym[d][m_n[d]] = sym;
               m_n[d]++;
            end
            if (model_is_match(d)) begin
               m_matches[d]++;
               m_out[d] = 1;
               if (cfg_hold[d] != 0) m_done[d] = 1;
               else if (cfg_ovl[d] == 0) m_n[d] = 0;
            end
         end
      end
      m_tick_exp = (m_cnt == DIVISOR - 1);
   endfunction

   function automatic int model_hist(int d);
      int h = 0;
      for (int i = 0; i < m_n[d]; i++) h = (h << 1) | m_sym[d][i];
      return h;
   endfunction

   function automatic int model_state(int d);
      if (m_done[d]) return 3;
      if (m_n[d] == 0) return 0;
      if (m_n[d] < PAT_LEN) return 1;
      return 2;
   endfunction

   // ---------------- checking helpers ----------------
   function automatic void chk(string name, int d, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d: actual=%0h required=%0h at %0t", name, d, act, exp, $time);
      end
   endfunction

   task automatic read_dut(input int d, output int h, output int o, output int s,
                           output int t, output int mc);
      mc = 0;
      case (d)
         0: begin
            h = int'(if0.HIST); o = int'(if0.OUT); s = int'(if0.STATE); t = int'(if0.TICK);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
            mc = int'(if0.MATCH_CNT);
`endif
         end
         1: begin
            h = int'(if1.HIST); o = int'(if1.OUT); s = int'(if1.STATE); t = int'(if1.TICK);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
            mc = int'(if1.MATCH_CNT);
`endif
         end
         default: begin
            h = int'(if2.HIST); o = int'(if2.OUT); s = int'(if2.STATE); t = int'(if2.TICK);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
            mc = int'(if2.MATCH_CNT);
`endif
         end
      endcase
   endtask

   task automatic check_all();
      int h, o, s, t, mc;
      for (int d = 0; d < ND; d++) begin
         read_dut(d, h, o, s, t, mc);
         pulse_cnt[d] += o;
         chk("tick",  d, t, int'(m_tick_exp));
         chk("hist",  d, h, model_hist(d));
         chk("out",   d, o, int'(m_out[d]));
         chk("state", d, s, model_state(d));
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
         chk("match_cnt", d, mc, m_matches[d] % (1 << cfg_cntw[d]));
`endif
      end
   endtask

   task automatic cycle();
      @(posedge clock_in);
      if (RESET) model_edge();
      #1;
      check_all();
   endtask

   task automatic wait_tick();
      last_tick = 0;
      for (int k = 0; k < 8 && !last_tick; k++) cycle();
      if (!last_tick) begin
         checks++; failures++;
         $display("FAIL tick_wait: actual=no tick required=tick within 8 cycles");
      end
   endtask

   task automatic press(input bit one, input bit zero);
      one_r = one; zero_r = zero;
      wait_tick();
      one_r = 0; zero_r = 0;
      wait_tick();
      $display("press one=%0d zero=%0d hist=%b/%b/%b out=%0d/%0d/%0d state=%0d/%0d/%0d",
               one, zero, if0.HIST, if1.HIST, if2.HIST, if0.OUT, if1.OUT, if2.OUT,
               if0.STATE, if1.STATE, if2.STATE);
   endtask

   // Asserts RESET between clock edges and checks the asynchronous clear
   // before any further edge arrives.
   task automatic do_reset();
      #2;
      RESET = 1'b0;
      #1;
      model_reset();
      chk("async_rst_hist",  0, int'(if0.HIST),  0);
      chk("async_rst_state", 0, int'(if0.STATE), 0);
      chk("async_rst_out",   0, int'(if0.OUT),   0);
      check_all();
      cycle();
      cycle();
      #2;
      RESET = 1'b1;
      for (int d = 0; d < ND; d++) pulse_cnt[d] = 0;
      $display("reset applied and released at %0t", $time);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit         one;
      bit         zero;
      logic [3:0] hist;
      bit         out;
      logic [1:0] state;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int h, o, s, t, mc;
      pat_v = PATTERN;
      tbl[0] = '{1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
      tbl[1] = '{1'b0, 1'b1, 4'b0010, 1'b0, 2'd1};
      tbl[2] = '{1'b0, 1'b1, 4'b0100, 1'b0, 2'd1};
      tbl[3] = '{1'b1, 1'b0, 4'b1001, 1'b1, 2'd3};
      tbl[4] = '{1'b1, 1'b0, 4'b1001, 1'b1, 2'd3};
      tbl[5] = '{1'b0, 1'b1, 4'b1001, 1'b1, 2'd3};

      model_reset();
      RESET = 1'b0;
      repeat (2) @(posedge clock_in);
      #1;
      check_all();
      #2;
      RESET = 1'b1;

      // Reset mid-fill
      press(1, 0);
      press(0, 1);
      chk("midfill_hist", 0, int'(if0.HIST), 4'b0010);
      do_reset();

      // Basic HOLD_OUT=1 match and frozen history, table-driven
      for (int i = 0; i < 6; i++) begin
         press(tbl[i].one, tbl[i].zero);
         chk("tbl_hist",  0, int'(if0.HIST),  int'(tbl[i].hist));
         chk("tbl_out",   0, int'(if0.OUT),   int'(tbl[i].out));
         chk("tbl_state", 0, int'(if0.STATE), int'(tbl[i].state));
      end
      do_reset();
      chk("out_after_reset", 0, int'(if0.OUT), 0);

      // Held button: one symbol only
      one_r = 1;
      for (int k = 0; k < 5; k++) wait_tick();
      one_r = 0;
      wait_tick();
      $display("held ONE for 5 ticks hist=%b state=%0d", if0.HIST, if0.STATE);
      chk("held_hist",  0, int'(if0.HIST),  4'b0001);
      chk("held_state", 0, int'(if0.STATE), 1);

      // Simultaneous press: ZERO wins
      press(1, 1);
      chk("simul_hist", 0, int'(if0.HIST), 4'b0010);
      do_reset();

      // Overlap vs. no-overlap pulse behaviour
      press(1, 0); press(0, 1); press(0, 1); press(1, 0);
      chk("noovl_state_after_match", 2, int'(if2.STATE), 0);
      chk("noovl_hist_after_match",  2, int'(if2.HIST),  0);
      press(0, 1); press(0, 1); press(1, 0);
      chk("ovl_pulses",   1, pulse_cnt[1], 2);
      chk("noovl_pulses", 2, pulse_cnt[2], 1);
      chk("ovl_hist",     1, int'(if1.HIST), 4'b1001);
      chk("noovl_hist",   2, int'(if2.HIST), 4'b0001);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
      read_dut(1, h, o, s, t, mc);
      chk("ovl_match_cnt", 1, mc, 2);
      read_dut(2, h, o, s, t, mc);
      chk("noovl_match_cnt", 2, mc, 1);
`endif
      do_reset();

      // Five separate matches on the 2-bit counter wrap it to 1
      for (int m = 0; m < 5; m++) begin
         press(1, 0); press(0, 1); press(0, 1); press(1, 0);
      end
      chk("five_match_pulses", 2, pulse_cnt[2], 5);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
      read_dut(2, h, o, s, t, mc);
      chk("match_cnt_wrap", 2, mc, 1);
`endif
      do_reset();

      // Randomised button activity against the reference model
      for (int c = 0; c < 3000; c++) begin
         one_r  = ($urandom_range(0, 3) == 0);
         zero_r = ($urandom_range(0, 3) == 0);
         cycle();
         if ($urandom_range(0, 599) == 0) begin
            one_r = 0; zero_r = 0;
            do_reset();
         end
      end
      $display("random phase done matches=%0d/%0d/%0d", m_matches[0], m_matches[1], m_matches[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
